// File: rtl/mac_relu_sequencer.sv
//-----------------------------------------------------------------------------
// mac_relu_sequencer
//
// Sequences int8 dot products with ReLU on the shared accelerator ALU. Operand
// word pairs (four packed signed int8 lanes each) are pulled through a
// valid/ready handshake. Each pair is reduced by an ALU packed-MAC op and
// added into a 32-bit wrapping accumulator with an ALU add. When RELU_EN is
// defined, a final ALU ReLU op clamps the sum at zero before the result is
// presented on a valid/ready result port.
//
// Build option:
//   RELU_EN  - when defined, the RELU state is compiled in and the result is
//              max(acc, 0). When undefined, the raw wrapped sum is returned.
//
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   start, len           job request and word-pair count (sampled in IDLE)
//   busy                 high whenever a job is in progress
//   op_valid, op_ready   operand pair handshake
//   op_a, op_b           packed int8 operand words (byte0 = lane 0)
//   alu_in1, alu_in2     ALU operands, driven by this block
//   alu_ctl, alu_sign    ALU op select and sign mode (sign is always 1)
//   alu_out              combinational ALU result
//   res_valid, res_ready result handshake
//   res_data             dot-product result
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mac_relu_sequencer #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic [31:0]      alu_in1,
   output logic [31:0]      alu_in2,
   output logic [4:0]       alu_ctl,
   output logic             alu_sign,
   input  logic [31:0]      alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data
);

   localparam logic [4:0] ALU_NOP  = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00010;
   localparam logic [4:0] ALU_MAC  = 5'b11011;
   localparam logic [4:0] ALU_RELU = 5'b11100;

   // Fixed encodings so the state register layout does not shift when the
   // RELU state is left out of the build.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      MAC   = 3'd2,
      ACC   = 3'd3,
`ifdef RELU_EN
      RELU  = 3'd4,
`endif
      DONE  = 3'd5
   } state_t;

   state_t           state_reg;
   logic [LEN_W-1:0] cnt_reg;
   logic [31:0]      acc_reg;
   logic [31:0]      a_reg;
   logic [31:0]      b_reg;
   logic [31:0]      prod_reg;
   logic             busy_reg;
   logic             op_ready_reg;
   logic             res_valid_reg;
   logic [31:0]      res_data_reg;

   assign busy      = busy_reg;
   assign op_ready  = op_ready_reg;
   assign res_valid = res_valid_reg;
   assign res_data  = res_data_reg;
   assign alu_sign  = 1'b1;

   // ALU port drive. Decoded purely from state and internal registers, so
   // there is no path from any input port to the ALU ports. alu_out only
   // ever lands in registers, which keeps the shared ALU loop acyclic.
   always_comb begin
      alu_ctl = ALU_NOP;
      alu_in1 = '0;
      alu_in2 = '0;
      case (state_reg)
         MAC: begin
            alu_ctl = ALU_MAC;
            alu_in1 = a_reg;
            alu_in2 = b_reg;
         end
         ACC: begin
            alu_ctl = ALU_ADD;
            alu_in1 = acc_reg;
            alu_in2 = prod_reg;
         end
`ifdef RELU_EN
         RELU: begin
            alu_ctl = ALU_RELU;
            alu_in1 = '0;
            alu_in2 = acc_reg;
         end
`endif
         default: begin
            alu_ctl = ALU_NOP;
         end
      endcase
   end

   // Control FSM. busy/op_ready/res_valid/res_data are registered and updated
   // on the same edge as the state transition that makes them true, so they
   // always reflect the current state exactly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         acc_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         prod_reg      <= '0;
         busy_reg      <= 1'b0;
         op_ready_reg  <= 1'b0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  cnt_reg  <= len;
                  acc_reg  <= '0;
                  busy_reg <= 1'b1;
                  if (len == '0) begin
`ifdef RELU_EN
                     // Empty vector still runs ReLU on the zero accumulator.
                     state_reg <= RELU;
`else
                     state_reg     <= DONE;
                     res_valid_reg <= 1'b1;
                     res_data_reg  <= '0;
`endif
                  end else begin
                     state_reg    <= FETCH;
                     op_ready_reg <= 1'b1;
                  end
               end
            end

            FETCH: begin
               if (op_valid && op_ready_reg) begin
                  a_reg        <= op_a;
                  b_reg        <= op_b;
                  op_ready_reg <= 1'b0;
                  state_reg    <= MAC;
               end
            end

            MAC: begin
               prod_reg  <= alu_out;
               state_reg <= ACC;
            end

            ACC: begin
               acc_reg <= alu_out;
               cnt_reg <= cnt_reg - LEN_W'(1);
               if (cnt_reg == LEN_W'(1)) begin
`ifdef RELU_EN
                  state_reg <= RELU;
`else
                  // Last pair: the fresh sum is the result.
                  state_reg     <= DONE;
                  res_valid_reg <= 1'b1;
                  res_data_reg  <= alu_out;
`endif
               end else begin
                  state_reg    <= FETCH;
                  op_ready_reg <= 1'b1;
               end
            end

`ifdef RELU_EN
            RELU: begin
               acc_reg       <= alu_out;
               res_data_reg  <= alu_out;
               res_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
`endif

            DONE: begin
               // A start seen here is deliberately ignored; only IDLE
               // samples start.
               if (res_ready) begin
                  res_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end

            default: begin
               state_reg     <= IDLE;
               busy_reg      <= 1'b0;
               op_ready_reg  <= 1'b0;
               res_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mac_relu_sequencer.sv
//-----------------------------------------------------------------------------
// tb_mac_relu_sequencer
//
// Directed bench for mac_relu_sequencer. A behavioural ALU sits on the ALU
// ports. Each job is driven with a word-pair table and checked against
// hand-computed results and latencies. Expected values follow RELU_EN when
// it is defined for the build.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mac_relu_sequencer;

   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             op_valid;
   logic             op_ready;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [31:0]      alu_in1;
   logic [31:0]      alu_in2;
   logic [4:0]       alu_ctl;
   logic             alu_sign;
   logic [31:0]      alu_out;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;

   int total = 0;
   int bad   = 0;

   logic [31:0] va [8];
   logic [31:0] vb [8];
   logic [31:0] ctl_seq;

   mac_relu_sequencer #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_ctl   (alu_ctl),
      .alu_sign  (alu_sign),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   always #5 clk = ~clk;

   // Behavioural shared ALU: packed int8 MAC, add, ReLU.
   function automatic logic [31:0] pmac(input logic [31:0] a, input logic [31:0] b);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++)
         s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
      return s;
   endfunction

   always_comb begin
      case (alu_ctl)
         5'b11011: alu_out = pmac(alu_in1, alu_in2);
         5'b00010: alu_out = alu_in1 + alu_in2;
         5'b11100: alu_out = alu_in2[31] ? 32'd0 : alu_in2;
         default:  alu_out = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int exp_latency(input int n, input int stall);
`ifdef RELU_EN
      return 3 * n + 1 + n * stall;
`else
      return 3 * n + n * stall;
`endif
   endfunction

   // Runs one job from the word-pair table. Entered and left at #1 after a
   // rising edge. stall = cycles op_valid stays low at the start of each
   // FETCH; hold = cycles res_ready stays low (with start pulsed) in DONE.
   task automatic do_job(input string tag, input int n, input int stall,
                         input int hold, input logic [31:0] exp_res);
      int   cycles;
      int   idx;
      int   gap;
      int   rdy_cnt;
      logic fire;
      cycles  = 0;
      idx     = 0;
      gap     = 0;
      rdy_cnt = 0;
      ctl_seq = '0;
      start     = 1'b1;
      len       = LEN_W'(n);
      op_valid  = 1'b0;
      res_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      len   = 8'hFF;              // changes after capture must not matter
      while (cycles < 200) begin
         if (alu_ctl != 5'd0) ctl_seq = {ctl_seq[26:0], alu_ctl};
         if (res_valid) break;
         if (op_ready) begin
            rdy_cnt++;
            if (gap < stall) begin
               op_valid = 1'b0;
               gap++;
            end else begin
               op_valid = 1'b1;
               op_a     = va[idx % 8];
               op_b     = vb[idx % 8];
            end
         end else begin
            // Junk offered while not ready must never be consumed.
            op_valid = 1'b1;
            op_a     = 32'h80808080;
            op_b     = 32'h80808080;
         end
         fire = op_valid & op_ready;
         @(posedge clk); #1;
         if (fire) begin
            idx++;
            gap = 0;
         end
         cycles++;
      end
      op_valid = 1'b0;
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_lat"},   cycles, exp_latency(n, stall));
      check({tag, "_data"},  res_data, exp_res);
      check({tag, "_pairs"}, idx, n);
      check({tag, "_rdy"},   rdy_cnt, n * (1 + stall));
      for (int k = 0; k < hold; k++) begin
         start     = 1'b1;
         res_ready = 1'b0;
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
         check({tag, "_hold_data"},  res_data, exp_res);
         check({tag, "_hold_busy"},  32'(busy), 32'd1);
      end
      start     = (hold > 0);     // start alongside the handshake is ignored
      res_ready = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      res_ready = 1'b0;
      check({tag, "_end_busy"},  32'(busy), 32'd0);
      check({tag, "_end_valid"}, 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      check({tag, "_idle_stay"}, 32'(busy), 32'd0);
      $display("job %s len=%0d stall=%0d hold=%0d res=%h cycles=%0d",
               tag, n, stall, hold, res_data, cycles);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},      32'(busy), 32'd0);
      check({tag, "_op_ready"},  32'(op_ready), 32'd0);
      check({tag, "_alu_in1"},   alu_in1, 32'd0);
      check({tag, "_alu_in2"},   alu_in2, 32'd0);
      check({tag, "_alu_ctl"},   32'(alu_ctl), 32'd0);
      check({tag, "_alu_sign"},  32'(alu_sign), 32'd1);
      check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_res_data"},  res_data, 32'd0);
   endtask

   initial begin
      logic [31:0] exp_seq;
      reset_n   = 1'b0;
      start     = 1'b0;
      len       = '0;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      $display("reset state checked");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Single word: 4+3+2+1 = 10.
      va[0] = 32'h01020304; vb[0] = 32'h01010101;
      do_job("single", 1, 0, 0, 32'h0000000A);
`ifdef RELU_EN
      exp_seq = {17'd0, 5'b11011, 5'b00010, 5'b11100};
`else
      exp_seq = {22'd0, 5'b11011, 5'b00010};
`endif
      check("single_ctl_seq", ctl_seq, exp_seq);

      // Negative sum (-4), with output backpressure and start spam in DONE.
      va[0] = 32'hFFFFFFFF; vb[0] = 32'h01010101;
`ifdef RELU_EN
      do_job("negative", 1, 0, 5, 32'h00000000);
`else
      do_job("negative", 1, 0, 5, 32'hFFFFFFFC);
`endif

      // Stalled input: 3 x (4 x 127*127) = 3 x 64516 = 193548.
      for (int i = 0; i < 3; i++) begin
         va[i] = 32'h7F7F7F7F;
         vb[i] = 32'h7F7F7F7F;
      end
      do_job("stalled", 3, 2, 0, 32'h0002F40C);

      // MAC extremes: 65536 + (-65024) + 10 = 522.
      va[0] = 32'h80808080; vb[0] = 32'h80808080;
      va[1] = 32'h80808080; vb[1] = 32'h7F7F7F7F;
      va[2] = 32'h01020304; vb[2] = 32'h01010101;
      do_job("extremes", 3, 0, 0, 32'h0000020A);

      // Empty vector.
      do_job("empty", 0, 0, 0, 32'h00000000);

      // Reset during MAC of a len = 4 job.
      start    = 1'b1;
      len      = 8'd4;
      op_valid = 1'b1;
      op_a     = 32'h11111111;
      op_b     = 32'h22222222;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (alu_ctl == 5'b11011) break;
         @(posedge clk); #1;
      end
      check("midrst_in_mac", 32'(alu_ctl), 32'h1B);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      $display("mid-job reset checked");
      op_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Post-reset job: 2 + 3 + 5 + 15 = 25.
      va[0] = 32'h05FB0302; vb[0] = 32'h03FF0101;
      do_job("post_reset", 1, 0, 0, 32'h00000019);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
